// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, FSM states and datapath select encodings
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - maps an opcode to the first state after DECODE
module opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output state_t     next_state,
  output logic       is_store
);

  always_comb begin
    next_state = TRAP;
    case (opcode)
      OP_R:              next_state = EXEC_R;
      OP_I:              next_state = EXEC_I;
      OP_LOAD, OP_STORE: next_state = MEM_ADDR;
      OP_BRANCH:         next_state = BRANCH;
      OP_JAL:            next_state = JAL;
      OP_JALR:           next_state = JALR;
      OP_LUI:            next_state = LUI;
      default:           next_state = TRAP;
    endcase
  end

  assign is_store = (opcode == OP_STORE);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main sequencing FSM for the multicycle RV32I datapath
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        imm,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        illegal
);

  state_t state;
  state_t dec_next;
  logic   dec_store;
  logic   unused_instr;

  assign unused_instr = ^instr[31:7];

  opcode_decode u_decode (
    .opcode     (instr[6:0]),
    .next_state (dec_next),
    .is_store   (dec_store)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        FETCH:                        if (mem_ready) state <= DECODE;
        DECODE:                       state <= dec_next;
        EXEC_R, EXEC_I, LUI:          state <= ALU_WB;
        MEM_ADDR:                     state <= dec_store ? MEM_WR : MEM_RD;
        MEM_RD:                       if (mem_ready) state <= MEM_WB;
        MEM_WR:                       if (mem_ready) state <= FETCH;
        ALU_WB, MEM_WB, BRANCH,
        JAL, JALR:                    state <= FETCH;
        TRAP:                         state <= TRAP;
        default:                      state <= FETCH;
      endcase
    end
  end

  // Everything is forced low while rst is high so an abandoned request never strobes.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = PCSRC_ALU;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RS2;
    ALUOp    = ALUOP_ADD;
    imm      = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = WB_ALUOUT;
    illegal  = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        EXEC_R: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
        end
        EXEC_I: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
          imm     = 1'b1;
        end
        ALU_WB: RegWrite = 1'b1;
        MEM_ADDR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = WB_MDR;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          IorD    = 1'b1;
        end
        BRANCH: begin
          ALUSrcA  = SRCA_RS1;
          ALUOp    = ALUOP_BRANCH;
          PCSource = PCSRC_ALUOUT;
          PCWrite  = zero;
        end
        JAL: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_ALUOUT;
          RegWrite = 1'b1;
          MemtoReg = WB_PC;
        end
        JALR: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_IMM;
          PCSource = PCSRC_JALR;
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
          MemtoReg = WB_PC;
        end
        LUI: begin
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_IMM;
        end
        TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_control;
  import rv_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsource;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       imm;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string  tag;
    state_t st;
    ctl_t   c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, IorD, IRWrite, PCWrite, imm, RegWrite, illegal;
  logic [1:0]  PCSource, ALUSrcA, ALUSrcB, ALUOp, MemtoReg;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  state_t seq_q[$];
  logic   rdy_q[$];
  ctl_t   obs;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSource  (PCSource),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .imm       (imm),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .illegal   (illegal)
  );

  assign obs = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
                ALUSrcB, ALUOp, imm, RegWrite, MemtoReg, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected control word per state, straight from the operation table.
  function automatic ctl_t model(state_t s, logic rdy, logic z);
    ctl_t c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1; c.srcb = 2'd1; c.irwrite = rdy; c.pcwrite = rdy; end
      DECODE:   begin c.srca = 2'd1; c.srcb = 2'd2; end
      EXEC_R:   begin c.srca = 2'd2; c.aluop = 2'b10; end
      EXEC_I:   begin c.srca = 2'd2; c.srcb = 2'd2; c.aluop = 2'b10; c.imm = 1; end
      ALU_WB:   c.regwrite = 1;
      MEM_ADDR: begin c.srca = 2'd2; c.srcb = 2'd2; end
      MEM_RD:   begin c.mem_req = 1; c.iord = 1; end
      MEM_WB:   begin c.regwrite = 1; c.memtoreg = 2'd1; end
      MEM_WR:   begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
      BRANCH:   begin c.srca = 2'd2; c.aluop = 2'b01; c.pcsource = 2'd1; c.pcwrite = z; end
      JAL:      begin c.pcwrite = 1; c.pcsource = 2'd1; c.regwrite = 1; c.memtoreg = 2'd2; end
      JALR:     begin c.srca = 2'd2; c.srcb = 2'd2; c.pcsource = 2'd2; c.pcwrite = 1;
                      c.regwrite = 1; c.memtoreg = 2'd2; end
      LUI:      begin c.srca = 2'd3; c.srcb = 2'd2; end
      TRAP:     c.illegal = 1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic step(input logic r, input logic rdy, input logic z);
    exp_t e;
    rst = r; mem_ready = rdy; zero = z;
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, 32'(obs), 32'(e.c));
      check({e.tag, ".st"}, 32'(dut.state), 32'(e.st));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic z);
    instr = ins;
    foreach (seq_q[i])
      sb.push_back('{tag: $sformatf("%s.%0d", tag, i), st: seq_q[i], c: model(seq_q[i], rdy_q[i], z)});
    foreach (seq_q[i]) step(1'b0, rdy_q[i], z);
  endtask

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset with mem_ready high: no request, no strobes.
    for (int i = 0; i < 2; i++) sb.push_back('{tag: $sformatf("reset.%0d", i), st: FETCH, c: '0});
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);

    seq_q = '{FETCH, DECODE, EXEC_R, ALU_WB};           rdy_q = '{1, 1, 1, 1};
    run("add", 32'h002081B3, 1'b0);
    seq_q = '{FETCH, DECODE, EXEC_I, ALU_WB};           rdy_q = '{1, 1, 1, 1};
    run("addi", 32'h00508093, 1'b0);
    seq_q = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_WB};
    rdy_q = '{1, 1, 1, 0, 0, 1, 1};
    run("lw", 32'h0000A103, 1'b0);
    seq_q = '{FETCH, DECODE, BRANCH};                   rdy_q = '{1, 1, 1};
    run("beq_t", 32'h00208463, 1'b1);
    run("beq_n", 32'h00208463, 1'b0);
    seq_q = '{FETCH, DECODE, MEM_ADDR, MEM_WR};         rdy_q = '{1, 1, 1, 1};
    run("sw", 32'h0020A023, 1'b0);
    seq_q = '{FETCH, DECODE, JAL};                      rdy_q = '{1, 1, 1};
    run("jal", 32'h0080006F, 1'b0);
    seq_q = '{FETCH, DECODE, JALR};                     rdy_q = '{1, 1, 1};
    run("jalr", 32'h00008067, 1'b0);

    // Reset while a fetch is waiting on memory.
    instr = 32'h002081B3;
    sb.push_back('{tag: "fwait", st: FETCH, c: model(FETCH, 1'b0, 1'b0)});
    sb.push_back('{tag: "fwait_rst", st: FETCH, c: '0});
    sb.push_back('{tag: "fwait_after", st: FETCH, c: model(FETCH, 1'b0, 1'b0)});
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Unsupported opcode parks in TRAP until reset.
    seq_q = '{FETCH, DECODE};                           rdy_q = '{1, 1};
    for (int i = 0; i < 10; i++) begin seq_q.push_back(TRAP); rdy_q.push_back(1'b1); end
    run("trap", 32'h0000007F, 1'b0);
    sb.push_back('{tag: "trap_rst", st: TRAP, c: '0});
    sb.push_back('{tag: "trap_exit", st: FETCH, c: model(FETCH, 1'b1, 1'b0)});
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
